// File: rtl/sisc_fetch.sv
// -----------------------------------------------------------------------------
// sisc_fetch -- instruction fetch stage of the SISC processor.
//
// Owns the fetch pointer, issues word reads to instruction memory over a
// req/ack handshake and buffers returned words with their addresses in a
// small prefetch FIFO that the instruction register pops via ir_load.
// A branch redirect flushes the FIFO and discards any read still in flight.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mem_req/mem_addr  read request and word address (held while mem_req=1)
//   mem_ack/mem_rdata memory response, meaningful only while mem_req=1
//   ir_load           consumer pop (ignored when instr_valid=0)
//   instr_valid       FIFO non-empty
//   instr_out/instr_pc FIFO head word and its address (hold when empty)
//   redirect/redirect_pc  branch taken, restart fetch at redirect_pc
//   fifo_count        number of buffered entries
// -----------------------------------------------------------------------------
module sisc_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     ir_load,
  output logic                     instr_valid,
  output logic [DATA_W-1:0]        instr_out,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] fpc_nx;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nx;
  logic [PTR_W-1:0]  wr_ptr_nx;
  logic [CNT_W-1:0]  count_nx;

  logic              push;
  logic              pop;
  logic              space;
  logic              head_from_push;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_pc;

  // ---------------------------------------------------------------------------
  // Next-state / FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    pop  = ir_load && instr_valid;
    push = (state == REQ) && mem_ack && !redirect;

    if (redirect) begin
      count_nx  = '0;
      rd_ptr_nx = '0;
      wr_ptr_nx = '0;
    end else begin
      count_nx  = fifo_count + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_nx = rd_ptr + PTR_W'(pop);
      wr_ptr_nx = wr_ptr + PTR_W'(push);
    end

    // A new request is only launched when a slot is guaranteed after this
    // edge's push/pop, so the push path can never overflow.
    space = count_nx < CNT_W'(DEPTH);

    state_nx = state;
    fpc_nx   = fpc;

    if (redirect) begin
      fpc_nx = redirect_pc;
      // An unacked outstanding read must complete before the new fetch; an
      // acked one (or none) lets the new fetch start next cycle. The FIFO was
      // just flushed, so a slot is always available.
      if ((state != IDLE) && !mem_ack) begin
        state_nx = DRAIN;
      end else begin
        state_nx = REQ;
      end
    end else begin
      case (state)
        IDLE: begin
          if (space) begin
            state_nx = REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            fpc_nx   = fpc + ADDR_W'(1);
            state_nx = space ? REQ : IDLE;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state_nx = space ? REQ : IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    // Head registers are loaded with whatever entry sits at the head after
    // this edge; when the FIFO drains to empty and refills in the same edge
    // the head is the word being pushed, which is not yet in storage.
    head_from_push = push && (rd_ptr_nx == wr_ptr);
    head_data      = head_from_push ? mem_rdata : data_mem[rd_ptr_nx];
    head_pc        = head_from_push ? fpc       : addr_mem[rd_ptr_nx];
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset needed: pointers and count gate visibility)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_rdata;
      addr_mem[wr_ptr] <= fpc;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fpc         <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
    end else begin
      state      <= state_nx;
      fpc        <= fpc_nx;
      mem_req    <= (state_nx != IDLE);
      // In DRAIN the address of the abandoned read stays on the bus until it
      // is acked; everywhere else the bus follows the fetch pointer.
      if (state_nx != DRAIN) begin
        mem_addr <= fpc_nx;
      end
      wr_ptr      <= wr_ptr_nx;
      rd_ptr      <= rd_ptr_nx;
      fifo_count  <= count_nx;
      instr_valid <= (count_nx != '0);
      if (count_nx != '0) begin
        instr_out <= head_data;
        instr_pc  <= head_pc;
      end
    end
  end

endmodule
